// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared parameters, checks and stage-register layout for pipelined_adder
package pipelined_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Number of pipeline stages, one CHUNK-bit ripple per stage.
  function automatic int num_stages(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 1;
  endfunction

  // Legal geometry: CHUNK >= 1 and WIDTH an exact multiple of CHUNK.
  function automatic bit params_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Stage k register layout: valid, sum_lo[lo_width], a_hi/b_hi[hi_width], carry.
  // The final stage has hi_width == 0 and holds the MSB carry-in instead.
  function automatic int lo_width(input int k, input int chunk);
    return chunk * (k + 1);
  endfunction

  function automatic int hi_width(input int k, input int width, input int chunk);
    return width - chunk * (k + 1);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational CHUNK-bit ripple-carry adder with carry into the top bit
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             CI,
  output logic [CHUNK-1:0] SUM,
  output logic             CO,
  output logic             C_MSB
);

  logic [CHUNK:0] c;

  // Bit-serial ripple: c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    SUM  = '0;
    c[0] = CI;
    for (int i = 0; i < CHUNK; i++) begin
      SUM[i]   = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign CO    = c[CHUNK];
  assign C_MSB = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready handshakes
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OFL,
  output logic             ZERO
);

  localparam int STAGES = num_stages(WIDTH, CHUNK);

  if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
    $fatal(1, "pipelined_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Whole pipeline advances together; bubbles move like valid beats.
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             ci0;

  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;
  assign b_eff    = B ^ {WIDTH{SUB}};
  assign ci0      = SUB | CI;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO_W = lo_width(k, CHUNK);
    localparam int HI_W = hi_width(k, WIDTH, CHUNK);

    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic             ci_c, co_c, cmsb_c;
    logic             valid_d, valid_q;
    logic [LO_W-1:0]  sum_d, sum_q;
    logic             carry_q;

    if (k == 0) begin : g_src
      assign a_c     = A[CHUNK-1:0];
      assign b_c     = b_eff[CHUNK-1:0];
      assign ci_c    = ci0;
      assign valid_d = IN_VALID;
      assign sum_d   = s_c;
    end else begin : g_src
      assign a_c     = g_stage[k-1].g_hi.a_hi_q[CHUNK-1:0];
      assign b_c     = g_stage[k-1].g_hi.b_hi_q[CHUNK-1:0];
      assign ci_c    = g_stage[k-1].carry_q;
      assign valid_d = g_stage[k-1].valid_q;
      assign sum_d   = {s_c, g_stage[k-1].sum_q};
    end

    adder_chunk #(.CHUNK(CHUNK)) u_add (
      .A    (a_c),
      .B    (b_c),
      .CI   (ci_c),
      .SUM  (s_c),
      .CO   (co_c),
      .C_MSB(cmsb_c)
    );

    // Stage register: valid, resolved low sum bits and chunk carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (en) begin
        valid_q <= valid_d;
        sum_q   <= sum_d;
        carry_q <= co_c;
      end
    end

    if (HI_W > 0) begin : g_hi
      logic [HI_W-1:0] a_hi_d, a_hi_q, b_hi_d, b_hi_q;
      logic            unused_cmsb;

      // Only the final chunk's MSB carry-in feeds the overflow flag.
      assign unused_cmsb = cmsb_c;

      if (k == 0) begin : g_hsrc
        assign a_hi_d = A[WIDTH-1:CHUNK];
        assign b_hi_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_hsrc
        assign a_hi_d = g_stage[k-1].g_hi.a_hi_q[HI_W+CHUNK-1:CHUNK];
        assign b_hi_d = g_stage[k-1].g_hi.b_hi_q[HI_W+CHUNK-1:CHUNK];
      end

      // Operand bits not yet consumed by a chunk adder travel with the beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (en) begin
          a_hi_q <= a_hi_d;
          b_hi_q <= b_hi_d;
        end
      end
    end else begin : g_last
      logic cmsb_q;

      // Carry into the result MSB, kept for the signed-overflow flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else if (en) begin
          cmsb_q <= cmsb_c;
        end
      end
    end
  end

  assign OUT_VALID = g_stage[STAGES-1].valid_q;
  assign SUM       = g_stage[STAGES-1].sum_q;
  assign CO        = g_stage[STAGES-1].carry_q;
  assign OFL       = g_stage[STAGES-1].carry_q ^ g_stage[STAGES-1].g_last.cmsb_q;
  assign ZERO      = (SUM == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder at 16/4 and 32/8
module tb_pipelined_adder;

  typedef struct packed {
    logic [15:0] s16;
    logic        c16;
    logic        o16;
    logic [31:0] s32;
    logic        c32;
    logic        o32;
    logic [31:0] t;
    logic        lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        rdy16, ov16, co16, ofl16, z16;
  logic [15:0] sum16;
  logic        rdy32, ov32, co32, ofl32, z32;
  logic [31:0] sum32;

  exp_t        q[$];
  exp_t        nxt;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(rdy16),
    .A(a_in[15:0]), .B(b_in[15:0]), .CI(ci), .SUB(sub),
    .OUT_VALID(ov16), .OUT_READY(out_ready), .SUM(sum16), .CO(co16), .OFL(ofl16), .ZERO(z16)
  );

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(rdy32),
    .A(a_in), .B(b_in), .CI(ci), .SUB(sub),
    .OUT_VALID(ov32), .OUT_READY(out_ready), .SUM(sum32), .CO(co32), .OFL(ofl32), .ZERO(z32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    exp_t        e;
    logic [31:0] be;
    logic        c0;
    logic [32:0] r32;
    logic [16:0] r16;
    be    = s ? ~b : b;
    c0    = s ? 1'b1 : c;
    r32   = {1'b0, a} + {1'b0, be} + {32'd0, c0};
    r16   = {1'b0, a[15:0]} + {1'b0, be[15:0]} + {16'd0, c0};
    e     = '0;
    e.s32 = r32[31:0];
    e.c32 = r32[32];
    e.o32 = (a[31] == be[31]) && (r32[31] != a[31]);
    e.s16 = r16[15:0];
    e.c16 = r16[16];
    e.o16 = (a[15] == be[15]) && (r16[15] != a[15]);
    return e;
  endfunction

  // One cycle: inspect outputs and handshakes mid-cycle, then cross one rising edge.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    check("in_ready16", rdy16, !ov16 || out_ready);
    check("in_ready32", rdy32, !ov32 || out_ready);
    if (ov16 || ov32) begin
      if (q.size() == 0) begin
        check("spurious_out", {ov16, ov32}, 0);
      end else begin
        e = q[0];
        check("out_valid16", ov16, 1);
        check("out_valid32", ov32, 1);
        check("sum16", sum16, e.s16);
        check("co16", co16, e.c16);
        check("ofl16", ofl16, e.o16);
        check("zero16", z16, e.s16 == 16'd0);
        check("sum32", sum32, e.s32);
        check("co32", co32, e.c32);
        check("ofl32", ofl32, e.o32);
        check("zero32", z32, e.s32 == 32'd0);
        if (out_ready) begin
          if (e.lat) check("latency", cyc - e.t, 4);
          void'(q.pop_front());
        end
      end
    end
    acc = in_valid && rdy16;
    if (acc) begin
      nxt.t = cyc;
      q.push_back(nxt);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic prep(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    a_in = a;
    b_in = b;
    ci   = c;
    sub  = s;
    nxt  = model(a, b, c, s);
  endtask

  task automatic push_beat();
    bit acc = 0;
    nxt.lat   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && !acc; k++) step(acc);
    check("beat_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 16 && q.size() > 0; k++) step(acc);
    step(acc);
    check("drain_empty", q.size(), 0);
  endtask

  // mode 0: always ready; mode 1: ready held low for the first cycles; mode 2: random
  task automatic stream(input int n, input int mode);
    int          i = 0;
    int          c = 0;
    bit          acc;
    logic [31:0] a, b;
    while (i < n && c < n * 8 + 100) begin
      if (mode == 2) begin
        a = $urandom;
        b = $urandom;
        prep(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid  = ($urandom_range(0, 4) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        a = i;
        b = 32'h100 * i;
        prep(a, b, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = (mode == 0) || (c >= 9);
      end
      nxt.lat = (mode == 0);
      step(acc);
      if (acc) i++;
      c++;
    end
    check("stream_beats", i, n);
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid16", ov16, 0);
    check("rst_sum16", sum16, 0);
    check("rst_co16", co16, 0);
    check("rst_ofl16", ofl16, 0);
    check("rst_zero16", z16, 1);
    check("rst_in_ready16", rdy16, 1);
    check("rst_out_valid32", ov32, 0);
    check("rst_sum32", sum32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    prep(32'h0000FFFF, 32'h1, 1'b0, 1'b0);
    nxt.s16 = 16'h0000; nxt.c16 = 1'b1; nxt.o16 = 1'b0;
    push_beat();
    prep(32'h00007FFF, 32'h1, 1'b0, 1'b0);
    nxt.s16 = 16'h8000; nxt.c16 = 1'b0; nxt.o16 = 1'b1;
    push_beat();
    prep(32'h5, 32'h7, 1'b0, 1'b1);
    nxt.s16 = 16'hFFFE; nxt.c16 = 1'b0; nxt.o16 = 1'b0;
    push_beat();
    prep(32'h5, 32'h7, 1'b1, 1'b1);
    nxt.s16 = 16'hFFFE; nxt.c16 = 1'b0; nxt.o16 = 1'b0;
    push_beat();
    prep(32'h8000, 32'h1, 1'b0, 1'b1);
    nxt.s16 = 16'h7FFF; nxt.c16 = 1'b1; nxt.o16 = 1'b1;
    push_beat();
    prep(32'hFFFFFFFF, 32'h1, 1'b1, 1'b0);
    nxt.s32 = 32'h1; nxt.c32 = 1'b1; nxt.s16 = 16'h1; nxt.c16 = 1'b1;
    push_beat();
    drain();

    stream(8, 0);
    drain();

    stream(6, 1);
    drain();

    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      prep(32'h1000 + k, 32'h22, 1'b0, 1'b0);
      nxt.lat  = 1'b1;
      in_valid = 1'b1;
      step(acc);
      check("inflight_accept", acc, 1);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_out_valid16", ov16, 0);
    check("mid_rst_sum16", sum16, 0);
    check("mid_rst_zero16", z16, 1);
    check("mid_rst_in_ready16", rdy16, 1);
    check("mid_rst_out_valid32", ov32, 0);
    check("mid_rst_sum32", sum32, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(acc);
    prep(32'h1234, 32'h4321, 1'b1, 1'b0);
    push_beat();
    drain();

    stream(10000, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
